// File: rtl/macro_hub_pkg.sv
// macro_hub_pkg: shared types and constants for the macro select hub.
//   fsm_state_t  - Wishbone access FSM states
//   *_OFF        - CSR offsets within the hub page (adr[7:0])
//   CTRL_EN_BIT  - enable bit position in CTRL
//   ERR_DATA_DEF - default read data returned with an error ack
package macro_hub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CSR_ACK,
        FWD,
        ERR_ACK
    } fsm_state_t;

    localparam logic [7:0]  CTRL_OFF     = 8'h00;
    localparam logic [7:0]  STATUS_OFF   = 8'h04;
    localparam logic [7:0]  TOCLR_OFF    = 8'h08;
    localparam int          CTRL_EN_BIT  = 31;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/macro_hub_mux.sv
// macro_hub_mux: registered N:1 one-hot mux with a force-safe override.
//   clk, rst_n  - clock, synchronous active-low reset (output -> SAFE)
//   force_safe  - drive SAFE instead of the selected lane
//   sel_oh      - one-hot lane select
//   din         - per-lane data, lane k at din[k]
//   dout        - registered output, 1 cycle latency
module macro_hub_mux #(
    parameter int           N    = 4,
    parameter int           W    = 8,
    parameter logic [W-1:0] SAFE = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                force_safe,
    input  logic [N-1:0]        sel_oh,
    input  logic [N-1:0][W-1:0] din,
    output logic [W-1:0]        dout
);

    logic [W-1:0] pick;

    always_comb begin
        pick = '0;
        for (int k = 0; k < N; k++)
            if (sel_oh[k]) pick |= din[k];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)          dout <= SAFE;
        else if (force_safe) dout <= SAFE;
        else                 dout <= pick;
    end

endmodule

// File: rtl/macro_select_hub.sv
// macro_select_hub: lets N user macros share one Caravel user-area interface.
//   wb_clk_i, wb_rst_n_i         - clock, synchronous active-low reset
//   wbs_*                        - Wishbone slave from the host
//   m_active                     - one-hot enable to the selected macro
//   m_wbs_stb / m_wbs_ack / m_wbs_dat - per-macro Wishbone strobe/ack/read data
//   m_io_out, m_io_oeb, m_la_data_out, m_irq - per-macro drive, flattened
//   io_out, io_oeb, la_data_out, user_irq    - muxed, registered pad drive
// CSR page at CSR_BASE: CTRL (SEL, EN), STATUS (TOCNT, gap), TOCLR.
module macro_select_hub
    import macro_hub_pkg::*;
#(
    parameter int          N_MACROS = 4,
    parameter int          SEL_W    = $clog2(N_MACROS),
    parameter logic [31:0] CSR_BASE = 32'h3000_0000,
    parameter int          TIMEOUT  = 64,
    parameter int          GAP      = 4,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    output logic [N_MACROS-1:0]       m_active,
    output logic [N_MACROS-1:0]       m_wbs_stb,
    input  logic [N_MACROS-1:0]       m_wbs_ack,
    input  logic [32*N_MACROS-1:0]    m_wbs_dat,
    input  logic [38*N_MACROS-1:0]    m_io_out,
    input  logic [38*N_MACROS-1:0]    m_io_oeb,
    input  logic [128*N_MACROS-1:0]   m_la_data_out,
    input  logic [3*N_MACROS-1:0]     m_irq,
    output logic [37:0]               io_out,
    output logic [37:0]               io_oeb,
    output logic [127:0]              la_data_out,
    output logic [2:0]                user_irq
);

    localparam int               TO_W     = $clog2(TIMEOUT + 1);
    localparam int               GAP_W    = $clog2(GAP + 1);
    localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(N_MACROS - 1);
    localparam logic [7:0]       SEL_MAX8 = 8'(N_MACROS - 1);

    fsm_state_t                    state;
    logic [SEL_W-1:0]              sel_q;
    logic                          en_q;
    logic [15:0]                   tocnt;
    logic [GAP_W-1:0]              gap_cnt;
    logic [TO_W-1:0]               wait_cnt;

    logic                          gap_active, is_csr, req;
    logic [7:0]                    off;
    logic [N_MACROS-1:0]           sel_oh;
    logic [N_MACROS-1:0][31:0]     m_dat_arr;
    logic [31:0]                   csr_rdata;
    logic [7:0]                    wr_sel_byte;
    logic                          wr_en;
    logic [SEL_W-1:0]              new_sel;
    logic                          ctrl_wr, ctrl_change, force_safe;
    logic                          unused_bits;

    assign gap_active = (gap_cnt != '0);
    assign off        = wbs_adr_i[7:0];
    assign is_csr     = (wbs_adr_i[31:8] == CSR_BASE[31:8]);
    assign req        = wbs_stb_i & wbs_cyc_i;
    assign m_dat_arr  = m_wbs_dat;
    assign m_active   = (en_q && !gap_active) ? sel_oh : '0;

    // Only bytes 0 (SEL) and 3 (EN) of CTRL carry state.
    assign unused_bits = ^{wbs_dat_i[30:8], wbs_sel_i[2:1]};

    always_comb begin
        sel_oh        = '0;
        sel_oh[sel_q] = 1'b1;
    end

    always_comb begin
        csr_rdata = '0;
        case (off)
            CTRL_OFF: begin
                csr_rdata[SEL_W-1:0]  = sel_q;
                csr_rdata[CTRL_EN_BIT] = en_q;
            end
            STATUS_OFF: csr_rdata = {15'b0, gap_active, tocnt};
            default:    csr_rdata = '0;
        endcase
    end

    // The whole low byte is compared so out-of-range SEL writes saturate
    // to the last macro instead of wrapping inside the SEL_W field.
    assign wr_sel_byte = wbs_sel_i[0] ? wbs_dat_i[7:0] : 8'(sel_q);
    assign wr_en       = wbs_sel_i[3] ? wbs_dat_i[CTRL_EN_BIT] : en_q;
    assign new_sel     = (wr_sel_byte > SEL_MAX8) ? SEL_MAX : wr_sel_byte[SEL_W-1:0];

    assign ctrl_wr     = (state == CSR_ACK) && wbs_cyc_i && wbs_we_i && (off == CTRL_OFF);
    assign ctrl_change = ctrl_wr && ((new_sel != sel_q) || (wr_en != en_q));

    // Including ctrl_change makes the pads go safe on the same edge the
    // new selection commits, so the old macro never overlaps the new one.
    assign force_safe  = !en_q || gap_active || ctrl_change;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state     <= IDLE;
            sel_q     <= '0;
            en_q      <= 1'b0;
            tocnt     <= '0;
            gap_cnt   <= '0;
            wait_cnt  <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            m_wbs_stb <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            if (gap_active) gap_cnt <= gap_cnt - 1'b1;
            if (ctrl_change) begin
                sel_q   <= new_sel;
                en_q    <= wr_en;
                gap_cnt <= GAP_W'(GAP);
            end
            case (state)
                IDLE: begin
                    // Skip the ack cycle: the host still holds stb while it
                    // samples the ack, which must not start a new access.
                    if (req && !wbs_ack_o) begin
                        wait_cnt <= '0;
                        if (is_csr)
                            state <= CSR_ACK;
                        else if (en_q && !gap_active) begin
                            state     <= FWD;
                            m_wbs_stb <= sel_oh;
                        end else
                            state <= ERR_ACK;
                    end
                end
                CSR_ACK: begin
                    state <= IDLE;
                    if (wbs_cyc_i) begin
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= csr_rdata;
                        if (wbs_we_i && off == TOCLR_OFF) tocnt <= '0;
                    end
                end
                FWD: begin
                    if (!wbs_cyc_i) begin
                        state     <= IDLE;
                        m_wbs_stb <= '0;
                    end else if (m_wbs_ack[sel_q]) begin
                        state     <= IDLE;
                        m_wbs_stb <= '0;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= m_dat_arr[sel_q];
                    end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                        state     <= ERR_ACK;
                        m_wbs_stb <= '0;
                        if (tocnt != 16'hFFFF) tocnt <= tocnt + 16'd1;
                    end else
                        wait_cnt <= wait_cnt + 1'b1;
                end
                ERR_ACK: begin
                    state <= IDLE;
                    if (wbs_cyc_i) begin
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= ERR_DATA;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    macro_hub_mux #(.N(N_MACROS), .W(38), .SAFE('0)) u_mux_io_out (
        .clk(wb_clk_i), .rst_n(wb_rst_n_i), .force_safe(force_safe),
        .sel_oh(sel_oh), .din(m_io_out), .dout(io_out)
    );

    macro_hub_mux #(.N(N_MACROS), .W(38), .SAFE('1)) u_mux_io_oeb (
        .clk(wb_clk_i), .rst_n(wb_rst_n_i), .force_safe(force_safe),
        .sel_oh(sel_oh), .din(m_io_oeb), .dout(io_oeb)
    );

    macro_hub_mux #(.N(N_MACROS), .W(128), .SAFE('0)) u_mux_la (
        .clk(wb_clk_i), .rst_n(wb_rst_n_i), .force_safe(force_safe),
        .sel_oh(sel_oh), .din(m_la_data_out), .dout(la_data_out)
    );

    macro_hub_mux #(.N(N_MACROS), .W(3), .SAFE('0)) u_mux_irq (
        .clk(wb_clk_i), .rst_n(wb_rst_n_i), .force_safe(force_safe),
        .sel_oh(sel_oh), .din(m_irq), .dout(user_irq)
    );

endmodule

// File: tb/tb_macro_select_hub.sv
module tb_macro_select_hub;

    localparam int NM = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [NM-1:0] m_active, m_wbs_stb, m_wbs_ack;
    logic [NM-1:0][31:0]  m_dat_a;
    logic [NM-1:0][37:0]  mio, moeb;
    logic [NM-1:0][127:0] mla;
    logic [NM-1:0][2:0]   mirq;
    logic [37:0]  io_out, io_oeb;
    logic [127:0] la;
    logic [2:0]   irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
        int          lat;
        logic [3:0]  stbx;
        int          ack1;
        bit          noise0;
        int          idle;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        bit          chk;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[29];

    int ack_after[NM];
    int wcnt[NM];
    bit noise0;

    macro_select_hub dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .m_active(m_active), .m_wbs_stb(m_wbs_stb), .m_wbs_ack(m_wbs_ack),
        .m_wbs_dat(m_dat_a), .m_io_out(mio), .m_io_oeb(moeb),
        .m_la_data_out(mla), .m_irq(mirq),
        .io_out(io_out), .io_oeb(io_oeb), .la_data_out(la), .user_irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                                input logic [3:0] s, input logic [31:0] e, input int l,
                                input logic [3:0] sx, input int a1, input bit n0, input int idl);
        vec_t v;
        v.adr = a; v.we = w; v.dat = d; v.sel = s; v.exp = e; v.lat = l;
        v.stbx = sx; v.ack1 = a1; v.noise0 = n0; v.idle = idl;
        return v;
    endfunction

    // Macro responders: ack after ack_after[k] cycles of strobe (0 = never);
    // macro 0 can be made to ack constantly to show stray acks are ignored.
    initial begin
        m_wbs_ack = '0;
        for (int k = 0; k < NM; k++) begin ack_after[k] = 0; wcnt[k] = 0; end
        forever begin
            @(negedge clk);
            m_wbs_ack    = '0;
            m_wbs_ack[0] = noise0;
            for (int k = 0; k < NM; k++) begin
                if (m_wbs_stb[k]) begin
                    wcnt[k]++;
                    if (ack_after[k] != 0 && wcnt[k] == ack_after[k]) m_wbs_ack[k] = 1'b1;
                end else
                    wcnt[k] = 0;
            end
        end
    end

    // Scoreboard side: every host ack pops one expectation.
    initial begin : mon
        logic prev_ack;
        exp_t e;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && wbs_ack_o) begin
                chk("ack_back_to_back", 128'(prev_ack), 128'(0));
                if (exp_q.size() == 0)
                    chk("unexpected_ack", 128'(1), 128'(0));
                else begin
                    e = exp_q.pop_front();
                    if (e.chk) chk("rdata", 128'(wbs_dat_o), 128'(e.dat));
                end
            end
            prev_ack = wbs_ack_o;
        end
    end

    task automatic wb_xfer(input vec_t v);
        int   n;
        exp_t e;
        @(negedge clk);
        adr = v.adr; we = v.we; dat = v.dat; sel = v.sel; stb = 1'b1; cyc = 1'b1;
        e.dat = v.exp; e.chk = !v.we;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("stb_route", 128'(m_wbs_stb), 128'(v.stbx));
        end while (!wbs_ack_o && n < 200);
        chk("ack_latency", 128'(n), 128'(v.lat));
        if (!wbs_ack_o && exp_q.size() > 0) void'(exp_q.pop_front());
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        ack_after[1] = v.ack1;
        noise0       = v.noise0;
        repeat (v.idle) @(negedge clk);
        wb_xfer(v);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ack"},    128'(wbs_ack_o), 128'(0));
        chk({tag, "_dat"},    128'(wbs_dat_o), 128'(0));
        chk({tag, "_active"}, 128'(m_active),  128'(0));
        chk({tag, "_mstb"},   128'(m_wbs_stb), 128'(0));
        chk({tag, "_io_out"}, 128'(io_out),    128'(0));
        chk({tag, "_io_oeb"}, 128'(io_oeb),    128'(38'h3F_FFFF_FFFF));
        chk({tag, "_la"},     la,              128'(0));
        chk({tag, "_irq"},    128'(irq),       128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no_finish want finish");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] CTRL = 32'h3000_0000, STAT = 32'h3000_0004, TOCL = 32'h3000_0008;
    localparam logic [31:0] DBEF = 32'hDEAD_BEEF;

    initial begin
        noise0 = 1'b0;
        stb = 0; cyc = 0; we = 0; sel = 4'h0; adr = '0; dat = '0;
        for (int k = 0; k < NM; k++) begin
            m_dat_a[k] = (k == 1) ? 32'h1234_5678 : 32'hBAD0_0000 + 32'(k);
            mio[k]     = {6'(k + 1), 32'hA5A5_0000 + 32'(k)};
            moeb[k]    = {6'h00, 32'h0000_FFF0 | 32'(k)};
            mla[k]     = {4{32'hC0DE_0000 + 32'(k)}};
            mirq[k]    = 3'(k + 1);
        end

        //            adr                         we dat           sel    exp            lat stbx  ack1 n0 idle
        tbl[0]  = mk(STAT,                        0, 0,            4'hF, 0,             2,  4'h0, 0, 0, 6);
        tbl[1]  = mk(CTRL,                        0, 0,            4'hF, 32'h8000_0002, 2,  4'h0, 0, 0, 6);
        tbl[2]  = mk(CTRL,                        1, 32'h7,        4'hF, 0,             2,  4'h0, 0, 0, 6);
        tbl[3]  = mk(CTRL,                        0, 0,            4'hF, 32'h0000_0003, 2,  4'h0, 0, 0, 6);
        tbl[4]  = mk(CTRL,                        1, 32'hFFFF_FF01,4'h1, 0,             2,  4'h0, 0, 0, 6);
        tbl[5]  = mk(CTRL,                        0, 0,            4'hF, 32'h0000_0001, 2,  4'h0, 0, 0, 6);
        tbl[6]  = mk(32'h3000_0010,               1, 32'hFFFF_FFFF,4'hF, 0,             2,  4'h0, 0, 0, 6);
        tbl[7]  = mk(32'h3000_000C,               0, 0,            4'hF, 0,             2,  4'h0, 0, 0, 6);
        tbl[8]  = mk(STAT,                        1, 32'hFFFF_FFFF,4'hF, 0,             2,  4'h0, 0, 0, 6);
        tbl[9]  = mk(CTRL,                        0, 0,            4'hF, 32'h0000_0001, 2,  4'h0, 0, 0, 6);
        tbl[10] = mk(32'h3000_1000,               0, 0,            4'hF, DBEF,          2,  4'h0, 0, 0, 6);
        tbl[11] = mk(STAT,                        0, 0,            4'hF, 0,             2,  4'h0, 0, 0, 6);
        tbl[12] = mk(CTRL,                        1, 32'h8000_0000,4'h8, 0,             2,  4'h0, 0, 0, 6);
        tbl[13] = mk(CTRL,                        0, 0,            4'hF, 32'h8000_0001, 2,  4'h0, 0, 0, 6);
        tbl[14] = mk(32'h3000_1000,               0, 0,            4'hF, 32'h1234_5678, 6,  4'h2, 5, 1, 6);
        tbl[15] = mk(32'h3000_1004,               1, 32'h55AA_55AA,4'hF, 0,             4,  4'h2, 3, 0, 6);
        tbl[16] = mk(32'h3000_2000,               0, 0,            4'hF, DBEF,          66, 4'h2, 0, 0, 6);
        tbl[17] = mk(STAT,                        0, 0,            4'hF, 32'h0000_0001, 2,  4'h0, 0, 0, 6);
        tbl[18] = mk(CTRL,                        1, 32'h8000_0001,4'hF, 0,             2,  4'h0, 0, 0, 6);
        tbl[19] = mk(STAT,                        0, 0,            4'hF, 32'h0000_0001, 2,  4'h0, 0, 0, 0);
        tbl[20] = mk(CTRL,                        1, 32'h0000_0001,4'hF, 0,             2,  4'h0, 0, 0, 6);
        tbl[21] = mk(STAT,                        0, 0,            4'hF, 32'h0001_0001, 2,  4'h0, 0, 0, 0);
        tbl[22] = mk(32'h3000_3000,               0, 0,            4'hF, DBEF,          2,  4'h0, 0, 0, 6);
        tbl[23] = mk(STAT,                        0, 0,            4'hF, 32'h0000_0001, 2,  4'h0, 0, 0, 6);
        tbl[24] = mk(TOCL,                        1, 0,            4'hF, 0,             2,  4'h0, 0, 0, 6);
        tbl[25] = mk(STAT,                        0, 0,            4'hF, 0,             2,  4'h0, 0, 0, 6);
        tbl[26] = mk(CTRL,                        1, 32'h8000_0005,4'hF, 0,             2,  4'h0, 0, 0, 6);
        tbl[27] = mk(CTRL,                        0, 0,            4'hF, 32'h8000_0003, 2,  4'h0, 0, 0, 6);
        tbl[28] = mk(CTRL,                        1, 32'h8000_0001,4'hF, 0,             2,  4'h0, 0, 0, 6);

        // Reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Select macro 2 with EN: 4-cycle break, then enable, then pads follow
        wb_xfer(mk(CTRL, 1, 32'h8000_0002, 4'hF, 0, 2, 4'h0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            chk("gap_active_off", 128'(m_active), 128'(0));
            chk("gap_io_oeb",     128'(io_oeb),   128'(38'h3F_FFFF_FFFF));
            @(negedge clk);
        end
        chk("active_after_gap", 128'(m_active), 128'(4'b0100));
        chk("io_out_lag",       128'(io_out),   128'(0));
        @(negedge clk);
        chk("io_out_m2",  128'(io_out), 128'(mio[2]));
        chk("io_oeb_m2",  128'(io_oeb), 128'(moeb[2]));
        chk("la_m2",      la,           mla[2]);
        chk("irq_m2",     128'(irq),    128'(mirq[2]));

        for (int i = 0; i < 29; i++) run_vec(tbl[i]);
        noise0 = 1'b0;

        // cyc dropped mid-forward: strobe released, no ack ever
        ack_after[1] = 0;
        repeat (8) @(negedge clk);
        adr = 32'h3000_4000; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_stb_held", 128'(m_wbs_stb), 128'(4'b0010));
        stb = 1'b0; cyc = 1'b0;
        @(negedge clk);
        chk("abort_stb_rel", 128'(m_wbs_stb), 128'(0));
        repeat (80) @(negedge clk);
        run_vec(mk(STAT, 0, 0, 4'hF, 0, 2, 4'h0, 0, 0, 0));

        // Reset during a forwarded access
        repeat (4) @(negedge clk);
        chk("pre_rst_io", 128'(io_out), 128'(mio[1]));
        adr = 32'h3000_5000; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_fwd_stb", 128'(m_wbs_stb), 128'(4'b0010));
        rst_n = 1'b0; stb = 1'b0; cyc = 1'b0;
        @(negedge clk);
        chk_reset_outs("rst_fwd");
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        run_vec(mk(CTRL, 0, 0, 4'hF, 0, 2, 4'h0, 0, 0, 0));

        // Reset during the break-before-make gap
        run_vec(mk(CTRL, 1, 32'h8000_0003, 4'hF, 0, 2, 4'h0, 0, 0, 4));
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outs("rst_gap");
        rst_n = 1'b1;
        run_vec(mk(STAT, 0, 0, 4'hF, 0, 2, 4'h0, 0, 0, 0));
        run_vec(mk(CTRL, 0, 0, 4'hF, 0, 2, 4'h0, 0, 0, 2));
        repeat (4) @(negedge clk);
        chk("sb_drained", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
